// File: rtl/cursor_ctrl_if.sv
// cursor_ctrl_if: push-button inputs and cursor position/status outputs of cursor_ctrl.
interface cursor_ctrl_if;
   logic       btn_up;
   logic       btn_down;
   logic       btn_left;
   logic       btn_right;
   logic [2:0] row;
   logic [2:0] col;
   logic       moved;
   logic       blocked;
   modport master (
      output btn_up, btn_down, btn_left, btn_right,
      input  row, col, moved, blocked
   );
   modport slave (
      input  btn_up, btn_down, btn_left, btn_right,
      output row, col, moved, blocked
   );
endinterface

// File: rtl/cursor_ctrl.sv
// cursor_ctrl: 7x5 cursor driven by push-buttons with hold-then-auto-repeat stepping.
// Define CURSOR_WRAP_EN to wrap around matrix edges instead of refusing the step.
module cursor_ctrl #(
   parameter int unsigned HOLD_CYCLES   = 25000000,
   parameter int unsigned REPEAT_CYCLES = 5000000
) (
   input logic          clk,
   input logic          rst,
   cursor_ctrl_if.slave bus
);
   localparam logic [25:0] HOLD_LAST = 26'(HOLD_CYCLES - 1);
   localparam logic [25:0] REP_LAST  = 26'(REPEAT_CYCLES - 1);
   typedef enum logic [1:0] {IDLE, HOLD, REPEAT} state_t;
   state_t      state;
   logic [3:0]  sync1, btn_s, dir, sdir;
   logic [25:0] cnt;
   logic [2:0]  row_q, col_q, nrow, ncol;
   logic        moved_q, blocked_q, one_hot, step, blk;
   logic        up, down, left, right;
   assign bus.row     = row_q;
   assign bus.col     = col_q;
   assign bus.moved   = moved_q;
   assign bus.blocked = blocked_q;
   always_comb begin
      one_hot = (btn_s != 4'd0) && ((btn_s & (btn_s - 4'd1)) == 4'd0);
      step    = state == IDLE ? one_hot :
                state == HOLD ? (btn_s == dir) && (cnt == HOLD_LAST) :
                                (btn_s == dir) && (cnt == REP_LAST);
      sdir    = state == IDLE ? btn_s : dir;
      {up, down, left, right} = sdir;
   end
`ifdef CURSOR_WRAP_EN
   always_comb begin
      blk  = 1'b0;
      nrow = up    ? (row_q == 3'd0 ? 3'd6 : row_q - 3'd1) :
             down  ? (row_q == 3'd6 ? 3'd0 : row_q + 3'd1) : row_q;
      ncol = left  ? (col_q == 3'd0 ? 3'd4 : col_q - 3'd1) :
             right ? (col_q == 3'd4 ? 3'd0 : col_q + 3'd1) : col_q;
   end
`else
   always_comb begin
      blk  = (up && row_q == 3'd0) || (down && row_q == 3'd6) ||
             (left && col_q == 3'd0) || (right && col_q == 3'd4);
      nrow = up ? row_q - 3'd1 : down ? row_q + 3'd1 : row_q;
      ncol = left ? col_q - 3'd1 : right ? col_q + 3'd1 : col_q;
   end
`endif
   always_ff @(posedge clk) begin
      if (rst) begin
         sync1     <= '0;
         btn_s     <= '0;
         dir       <= '0;
         cnt       <= '0;
         state     <= IDLE;
         row_q     <= '0;
         col_q     <= '0;
         moved_q   <= 1'b0;
         blocked_q <= 1'b0;
      end else begin
         sync1     <= {bus.btn_up, bus.btn_down, bus.btn_left, bus.btn_right};
         btn_s     <= sync1;
         moved_q   <= step && !blk;
         blocked_q <= step && blk;
         if (step && !blk) begin
            row_q <= nrow;
            col_q <= ncol;
         end
         case (state)
            IDLE: if (one_hot) begin
               dir   <= btn_s;
               cnt   <= '0;
               state <= HOLD;
            end
            HOLD: if (btn_s != dir) begin
               cnt   <= '0;
               state <= IDLE;
            end else if (cnt == HOLD_LAST) begin
               cnt   <= '0;
               state <= REPEAT;
            end else cnt <= cnt + 26'd1;
            default: if (btn_s != dir) begin
               cnt   <= '0;
               state <= IDLE;
            end else if (cnt == REP_LAST) cnt <= '0;
            else cnt <= cnt + 26'd1;
         endcase
      end
   end
endmodule

// File: tb/tb_cursor_ctrl.sv
// tb_cursor_ctrl: directed checks of cursor_ctrl stepping, hold/repeat timing, edges and reset.
module tb_cursor_ctrl;
   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] btn;
   int         checks = 0;
   int         errors = 0;
   logic [2:0] exp_row;
   logic       exp_mv;
   cursor_ctrl_if bus ();
   assign bus.btn_up    = btn[3];
   assign bus.btn_down  = btn[2];
   assign bus.btn_left  = btn[1];
   assign bus.btn_right = btn[0];
   cursor_ctrl #(.HOLD_CYCLES(4), .REPEAT_CYCLES(2)) dut (.clk(clk), .rst(rst), .bus(bus));
   always #5 clk = ~clk;
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask
   initial begin
      btn = 4'b0000;
      rst = 1'b1;
      tick();
      tick();
      check("rst_row", 32'(bus.row), 0);
      check("rst_col", 32'(bus.col), 0);
      check("rst_moved", 32'(bus.moved), 0);
      check("rst_blocked", 32'(bus.blocked), 0);
      rst = 1'b0;
      tick();
      // single-cycle right press: step lands two edges after capture
      btn = 4'b0001;
      tick();
      btn = 4'b0000;
      tick();
      check("r1_col_n1", 32'(bus.col), 0);
      check("r1_mv_n1", 32'(bus.moved), 0);
      tick();
      check("r1_col", 32'(bus.col), 1);
      check("r1_moved", 32'(bus.moved), 1);
      check("r1_blocked", 32'(bus.blocked), 0);
      repeat (6) tick();
      check("r1_after_col", 32'(bus.col), 1);
      check("r1_after_mv", 32'(bus.moved), 0);
      // hold down: steps at N+2, N+6, N+8, N+10, N+12
      btn = 4'b0100;
      exp_row = 3'd0;
      for (int k = 0; k <= 16; k++) begin
         tick();
         if (k == 11) btn = 4'b0000;
         exp_mv = (k == 2 || k == 6 || k == 8 || k == 10 || k == 12);
         if (exp_mv) exp_row = exp_row + 3'd1;
         check($sformatf("hold_mv_%0d", k), 32'(bus.moved), 32'(exp_mv));
         check($sformatf("hold_row_%0d", k), 32'(bus.row), 32'(exp_row));
      end
      // simultaneous left+up: nothing happens
      btn = 4'b1010;
      for (int k = 0; k < 8; k++) begin
         tick();
         check("multi_mv", 32'(bus.moved), 0);
         check("multi_blk", 32'(bus.blocked), 0);
      end
      check("multi_row", 32'(bus.row), 5);
      check("multi_col", 32'(bus.col), 1);
      btn = 4'b0000;
      repeat (4) tick();
      // down step, then extra left press aborts HOLD
      btn = 4'b0100;
      repeat (3) tick();
      check("dl_row", 32'(bus.row), 6);
      check("dl_mv", 32'(bus.moved), 1);
      btn = 4'b0110;
      for (int k = 0; k < 6; k++) begin
         tick();
         check("dl_abort_mv", 32'(bus.moved), 0);
         check("dl_abort_blk", 32'(bus.blocked), 0);
      end
      check("dl_abort_row", 32'(bus.row), 6);
      btn = 4'b0010;
      tick();
      tick();
      check("dl_left_pre", 32'(bus.col), 1);
      tick();
      check("dl_left_col", 32'(bus.col), 0);
      check("dl_left_mv", 32'(bus.moved), 1);
      btn = 4'b0000;
      repeat (4) tick();
      check("dl_end_col", 32'(bus.col), 0);
      check("dl_end_row", 32'(bus.row), 6);
      // edge behaviour from origin
      rst = 1'b1;
      tick();
      rst = 1'b0;
      tick();
      btn = 4'b1000;
      tick();
      btn = 4'b0000;
      tick();
      tick();
`ifdef CURSOR_WRAP_EN
      check("up_edge_row", 32'(bus.row), 6);
      check("up_edge_mv", 32'(bus.moved), 1);
      check("up_edge_blk", 32'(bus.blocked), 0);
`else
      check("up_edge_row", 32'(bus.row), 0);
      check("up_edge_mv", 32'(bus.moved), 0);
      check("up_edge_blk", 32'(bus.blocked), 1);
`endif
      tick();
      check("up_edge_blk_end", 32'(bus.blocked), 0);
      check("up_edge_mv_end", 32'(bus.moved), 0);
      repeat (3) tick();
      btn = 4'b0010;
      tick();
      btn = 4'b0000;
      tick();
      tick();
`ifdef CURSOR_WRAP_EN
      check("left_edge_col", 32'(bus.col), 4);
      check("left_edge_blk", 32'(bus.blocked), 0);
`else
      check("left_edge_col", 32'(bus.col), 0);
      check("left_edge_blk", 32'(bus.blocked), 1);
`endif
      repeat (4) tick();
      // reset while in REPEAT with right still held
      rst = 1'b1;
      tick();
      rst = 1'b0;
      btn = 4'b0001;
      repeat (10) tick();
      check("rr_col_pre", 32'(bus.col), 3);
      rst = 1'b1;
      tick();
      check("rr_rst_col", 32'(bus.col), 0);
      check("rr_rst_row", 32'(bus.row), 0);
      check("rr_rst_mv", 32'(bus.moved), 0);
      rst = 1'b0;
      tick();
      tick();
      check("rr_col_e2", 32'(bus.col), 0);
      tick();
      check("rr_col_e3", 32'(bus.col), 1);
      check("rr_mv_e3", 32'(bus.moved), 1);
      btn = 4'b0000;
      repeat (3) tick();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
